// File: rtl/qosc_sample_reader.sv
// Captures (optionally decimated) oscillator re/im pairs into a FIFO and streams them byte-serially.
// Define QOSC_READER_TIMESTAMP_EN to append an 8-bit step timestamp byte to every record.
module qosc_sample_reader #(
    parameter int DEPTH   = 8,
    parameter int DECIM_W = 4
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_sample_stb,
    input  logic [7:0]             i_accu_re,
    input  logic [7:0]             i_accu_im,
    input  logic                   i_arm,
    input  logic [DECIM_W-1:0]     i_decim,
    input  logic                   i_clr_ovf,
    output logic [7:0]             o_out_data,
    output logic                   o_out_valid,
    input  logic                   i_out_ready,
    output logic                   o_out_last,
    output logic [$clog2(DEPTH):0] o_level,
    output logic                   o_overflow
);
    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;
`ifdef QOSC_READER_TIMESTAMP_EN
    localparam int EW = 24;
    typedef enum logic [1:0] {IDLE, RE, IM, TS} state_t;
    localparam state_t ST_FINAL = TS;
`else
    localparam int EW = 16;
    typedef enum logic [1:0] {IDLE, RE, IM} state_t;
    localparam state_t ST_FINAL = IM;
`endif
    localparam logic [LW-1:0] FULL = LW'(DEPTH);

    state_t             r_state, w_state_next;
    logic [EW-1:0]      r_mem [DEPTH];
    logic [PW-1:0]      r_wptr, r_rptr, w_rptr_inc;
    logic [LW-1:0]      r_level;
    logic [DECIM_W-1:0] r_dcnt;
    logic               r_overflow;
    logic [7:0]         r_data, w_data_next;
    logic               r_valid, w_valid_next;
    logic               r_last, w_last_next;
    logic               w_capture, w_push, w_pop, w_hs;
    logic [EW-1:0]      w_entry, w_head;
    logic [7:0]         w_next_re;

`ifdef QOSC_READER_TIMESTAMP_EN
    logic [7:0] r_ts;

    // Counts every oscillator step, captured or not, so gaps in a record stream are visible.
    always_ff @(posedge i_clk) begin
        if (i_rst)
            r_ts <= '0;
        else if (i_sample_stb)
            r_ts <= r_ts + 8'd1;
    end

    assign w_entry = {i_accu_re, i_accu_im, r_ts};
`else
    assign w_entry = {i_accu_re, i_accu_im};
`endif

    assign w_capture  = i_sample_stb & i_arm & (r_dcnt == '0);
    assign w_push     = w_capture & ((r_level != FULL) | w_pop);
    assign w_rptr_inc = r_rptr + PW'(1);
    assign w_head     = r_mem[r_rptr];
    assign w_next_re  = r_mem[w_rptr_inc][EW-1 -: 8];
    assign w_hs       = r_valid & i_out_ready;

    always_ff @(posedge i_clk) begin
        if (i_rst || !i_arm)
            r_dcnt <= '0;
        else if (i_sample_stb)
            r_dcnt <= (r_dcnt == '0) ? i_decim : r_dcnt - DECIM_W'(1);
    end

    always_ff @(posedge i_clk) begin
        if (w_push)
            r_mem[r_wptr] <= w_entry;
    end

    // A push into a full FIFO is only legal alongside a pop, so occupancy then stays at DEPTH.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_level    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push)
                r_wptr <= r_wptr + PW'(1);
            if (w_pop)
                r_rptr <= w_rptr_inc;
            if (w_push && !w_pop)
                r_level <= r_level + LW'(1);
            else if (!w_push && w_pop)
                r_level <= r_level - LW'(1);
            if (w_capture && !w_push)
                r_overflow <= 1'b1;
            else if (i_clr_ovf)
                r_overflow <= 1'b0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= IDLE;
            r_data  <= '0;
            r_valid <= 1'b0;
            r_last  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_data  <= w_data_next;
            r_valid <= w_valid_next;
            r_last  <= w_last_next;
        end
    end

    // The head is popped only on the final byte, so a drop can never split a record.
    always_comb begin
        w_state_next = r_state;
        w_data_next  = r_data;
        w_valid_next = r_valid;
        w_last_next  = r_last;
        w_pop        = 1'b0;
        case (r_state)
            IDLE: begin
                if (r_level != '0) begin
                    w_data_next  = w_head[EW-1 -: 8];
                    w_valid_next = 1'b1;
                    w_last_next  = 1'b0;
                    w_state_next = RE;
                end
            end
            RE: begin
                if (w_hs) begin
                    w_data_next  = w_head[EW-9 -: 8];
                    w_last_next  = (ST_FINAL == IM);
                    w_state_next = IM;
                end
            end
`ifdef QOSC_READER_TIMESTAMP_EN
            IM: begin
                if (w_hs) begin
                    w_data_next  = w_head[7:0];
                    w_last_next  = 1'b1;
                    w_state_next = TS;
                end
            end
`endif
            default: ;
        endcase
        if (r_state == ST_FINAL && w_hs) begin
            w_pop = 1'b1;
            if (r_level > LW'(1)) begin
                w_data_next  = w_next_re;
                w_last_next  = 1'b0;
                w_state_next = RE;
            end else begin
                w_valid_next = 1'b0;
                w_last_next  = 1'b0;
                w_state_next = IDLE;
            end
        end
    end

    assign o_out_data  = r_data;
    assign o_out_valid = r_valid;
    assign o_out_last  = r_last;
    assign o_level     = r_level;
    assign o_overflow  = r_overflow;
endmodule

// File: tb/tb_qosc_sample_reader.sv
// Directed, table-driven bench for qosc_sample_reader; also exercises the timestamp build when
// QOSC_READER_TIMESTAMP_EN is defined.
module tb_qosc_sample_reader;
    localparam int DEPTH   = 8;
    localparam int DECIM_W = 4;
`ifdef QOSC_READER_TIMESTAMP_EN
    localparam int RB = 3;
`else
    localparam int RB = 2;
`endif

    logic                   clock = 1'b0;
    logic                   reset = 1'b0;
    logic                   sampleStb = 1'b0;
    logic [7:0]             accuRe = '0;
    logic [7:0]             accuIm = '0;
    logic                   arm = 1'b0;
    logic [DECIM_W-1:0]     decim = '0;
    logic                   clrOvf = 1'b0;
    logic [7:0]             outData;
    logic                   outValid;
    logic                   outReady = 1'b0;
    logic                   outLast;
    logic [$clog2(DEPTH):0] level;
    logic                   overflow;

    typedef struct packed {
        logic [7:0] data;
        logic       last;
    } beat_t;

    typedef struct {
        logic [DECIM_W-1:0] decim;
        int                 steps;
        int                 expCount;
        logic [7:0]         expLastRe;
    } vec_t;

    beat_t beats[$];
    vec_t  vecs[5];
    int    testsRun = 0;
    int    testsFailed = 0;

    qosc_sample_reader #(.DEPTH(DEPTH), .DECIM_W(DECIM_W)) dut (
        .i_clk(clock),
        .i_rst(reset),
        .i_sample_stb(sampleStb),
        .i_accu_re(accuRe),
        .i_accu_im(accuIm),
        .i_arm(arm),
        .i_decim(decim),
        .i_clr_ovf(clrOvf),
        .o_out_data(outData),
        .o_out_valid(outValid),
        .i_out_ready(outReady),
        .o_out_last(outLast),
        .o_level(level),
        .o_overflow(overflow)
    );

    always #5 clock = ~clock;

    // Inputs change 1 time unit after posedge, so negedge sees the values the next edge will use.
    always @(negedge clock) begin
        if (!reset && outValid && outReady)
            beats.push_back({outData, outLast});
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [7:0] re, input logic [7:0] im);
        sampleStb = 1'b1;
        accuRe    = re;
        accuIm    = im;
        tick();
        sampleStb = 1'b0;
        repeat (3) tick();
    endtask

    task automatic doReset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic waitDrain(input string name);
        int n = 0;
        while ((level != 0 || outValid) && n < 400) begin
            tick();
            n++;
        end
        checkOutput({name, " drained"}, 32'(n < 400), 1);
    endtask

    task automatic checkRecord(input string name, input int idx, input logic [7:0] re, input logic [7:0] im);
        int base = idx * RB;
        checkOutput({name, " present"}, 32'(beats.size() >= base + RB), 1);
        if (beats.size() >= base + RB) begin
            checkOutput({name, " re"}, beats[base].data, re);
            checkOutput({name, " re last"}, beats[base].last, 0);
            checkOutput({name, " im"}, beats[base+1].data, im);
            checkOutput({name, " im last"}, beats[base+1].last, RB == 2);
`ifdef QOSC_READER_TIMESTAMP_EN
            checkOutput({name, " ts last"}, beats[base+2].last, 1);
`endif
        end
    endtask

    initial begin
        vecs[0] = '{4'd0, 5, 5, 8'd4};
        vecs[1] = '{4'd2, 9, 3, 8'd6};
        vecs[2] = '{4'd3, 10, 3, 8'd8};
        vecs[3] = '{4'd1, 7, 4, 8'd6};
        vecs[4] = '{4'd7, 8, 1, 8'd0};

        // Reset state and single-record latency.
        arm = 1'b1;
        decim = '0;
        outReady = 1'b1;
        doReset();
        checkOutput("reset valid", outValid, 0);
        checkOutput("reset last", outLast, 0);
        checkOutput("reset data", outData, 8'h00);
        checkOutput("reset level", level, 0);
        checkOutput("reset overflow", overflow, 0);

        sampleStb = 1'b1;
        accuRe = 8'h40;
        accuIm = 8'hC0;
        tick();
        sampleStb = 1'b0;
        checkOutput("n+1 level", level, 1);
        checkOutput("n+1 valid", outValid, 0);
        tick();
        checkOutput("n+2 valid", outValid, 1);
        checkOutput("n+2 data", outData, 8'h40);
        checkOutput("n+2 last", outLast, 0);
        tick();
        checkOutput("n+3 data", outData, 8'hC0);
        checkOutput("n+3 last", outLast, RB == 2);
`ifdef QOSC_READER_TIMESTAMP_EN
        tick();
        checkOutput("n+4 ts", outData, 8'h00);
        checkOutput("n+4 last", outLast, 1);
`endif
        tick();
        checkOutput("end valid", outValid, 0);
        checkOutput("end level", level, 0);

        // Decimation table: re = step index, captured steps are multiples of decim+1.
        doReset();
        for (int v = 0; v < 5; v++) begin
            arm = 1'b0;
            tick();
            arm = 1'b1;
            decim = vecs[v].decim;
            beats.delete();
            for (int s = 0; s < vecs[v].steps; s++)
                applyStimulus(8'(s), ~8'(s));
            waitDrain($sformatf("decim%0d", v));
            checkOutput($sformatf("decim%0d count", v), beats.size(), vecs[v].expCount * RB);
            for (int k = 0; k < vecs[v].expCount; k++)
                checkRecord($sformatf("decim%0d rec%0d", v, k), k,
                            8'(k * (vecs[v].decim + 1)), ~8'(k * (vecs[v].decim + 1)));
            if (beats.size() >= vecs[v].expCount * RB)
                checkOutput($sformatf("decim%0d last re", v),
                            beats[(vecs[v].expCount - 1) * RB].data, vecs[v].expLastRe);
        end

        // Overflow: DEPTH+2 captures with the host stalled.
        doReset();
        decim = '0;
        outReady = 1'b0;
        beats.delete();
        for (int i = 0; i < DEPTH + 2; i++)
            applyStimulus(8'h10 + 8'(i), 8'(i) ^ 8'h5A);
        checkOutput("ovf level", level, DEPTH);
        checkOutput("ovf flag", overflow, 1);
        repeat (3) tick();
        checkOutput("stall valid", outValid, 1);
        checkOutput("stall data", outData, 8'h10);
        checkOutput("stall last", outLast, 0);
        outReady = 1'b1;
        waitDrain("ovf");
        checkOutput("ovf count", beats.size(), DEPTH * RB);
        for (int k = 0; k < DEPTH; k++)
            checkRecord($sformatf("ovf rec%0d", k), k, 8'h10 + 8'(k), 8'(k) ^ 8'h5A);
        checkOutput("ovf sticky", overflow, 1);
        clrOvf = 1'b1;
        tick();
        clrOvf = 1'b0;
        checkOutput("ovf cleared", overflow, 0);

        // Full FIFO: capture coincident with the final-byte handshake is accepted.
        outReady = 1'b0;
        for (int i = 0; i < DEPTH; i++)
            applyStimulus(8'h80 + 8'(i), 8'(i));
        checkOutput("full level", level, DEPTH);
        outReady = 1'b1;
        tick();
`ifdef QOSC_READER_TIMESTAMP_EN
        tick();
`endif
        checkOutput("full final byte", outLast, 1);
        sampleStb = 1'b1;
        accuRe = 8'hEE;
        accuIm = 8'hEF;
        tick();
        sampleStb = 1'b0;
        outReady = 1'b0;
        checkOutput("coinc level", level, DEPTH);
        checkOutput("coinc overflow", overflow, 0);
        checkOutput("coinc next re", outData, 8'h81);
        checkOutput("coinc next last", outLast, 0);
        beats.delete();
        outReady = 1'b1;
        waitDrain("coinc");
        checkOutput("coinc count", beats.size(), DEPTH * RB);
        for (int k = 0; k < DEPTH - 1; k++)
            checkRecord($sformatf("coinc rec%0d", k), k, 8'h81 + 8'(k), 8'(k + 1));
        checkRecord("coinc new", DEPTH - 1, 8'hEE, 8'hEF);

        // Reset in the middle of a record.
        doReset();
        outReady = 1'b0;
        applyStimulus(8'h22, 8'h33);
        checkOutput("mid valid", outValid, 1);
        outReady = 1'b1;
        tick();
        outReady = 1'b0;
        checkOutput("mid im byte", outData, 8'h33);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checkOutput("mid rst valid", outValid, 0);
        checkOutput("mid rst level", level, 0);
        checkOutput("mid rst data", outData, 8'h00);
        beats.delete();
        outReady = 1'b1;
        applyStimulus(8'h11, 8'h12);
        waitDrain("post rst");
        checkOutput("post rst count", beats.size(), RB);
        checkRecord("post rst rec", 0, 8'h11, 8'h12);

`ifdef QOSC_READER_TIMESTAMP_EN
        // Timestamp wrap across 258 captured steps.
        doReset();
        decim = '0;
        outReady = 1'b1;
        beats.delete();
        for (int s = 0; s < 258; s++)
            applyStimulus(8'(s), 8'(s + 1));
        waitDrain("ts");
        checkOutput("ts count", beats.size(), 258 * RB);
        for (int k = 0; k < 258; k++) begin
            checkRecord($sformatf("ts rec%0d", k), k, 8'(k), 8'(k + 1));
            if (beats.size() >= k * RB + RB)
                checkOutput($sformatf("ts value%0d", k), beats[k*RB+2].data, 8'(k));
        end
`endif

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end
endmodule

// File: doc/qosc_sample_reader.md
# qosc_sample_reader

Read-side companion to the quadrature oscillator. Captures the 8-bit real/imaginary accumulator pair on each synchronized oscillator step (optionally decimated) into a small FIFO. Streams the pairs out byte-serially over a valid/ready interface, so a host can read contiguous waveform records through the bidirectional pins instead of sampling live outputs. Sits between the oscillator core and the top-level pin mux, in the `clk` domain.

## Interface
Parameters:
- `DEPTH`, default 8: FIFO entries (sample pairs); power of two, 2..32.
- `DECIM_W`, default 4: width of the decimation register.

Ports:
- `clk`  in  1: system clock; only clock.
- `rst`  in  1: synchronous, active-high reset.
- `sample_stb`  in  1: one-`clk` pulse per oscillator step (synchronized `takt` edge).
- `accu_re`  in  8: real accumulator, valid while `sample_stb` is high.
- `accu_im`  in  8: imaginary accumulator, valid while `sample_stb` is high.
- `arm`  in  1: capture enable (level).
- `decim`  in  DECIM_W: capture every (`decim`+1)-th step.
- `clr_ovf`  in  1: clears the sticky overflow flag.
- `out_data`  out  8: stream byte.
- `out_valid`  out  1: `out_data` valid.
- `out_ready`  in  1: host accepts the byte.
- `out_last`  out  1: final byte of a record.
- `level`  out  $clog2(DEPTH)+1: FIFO occupancy, 0..DEPTH.
- `overflow`  out  1: sticky; a capture was dropped.

## Operation
- **Decimation counter** `dcnt`:
  - Counts only on `sample_stb` while `arm` is high.
  - A step is a capture when `dcnt`==0.
  - `dcnt` reloads to `decim` on a capture and decrements otherwise.
  - Deasserting `arm` forces `dcnt` to 0, so the first step after re-arm is captured.
- **FIFO**:
  - Entries are {re, im}, 16 bits; pointers wrap modulo DEPTH.
  - A capture pushes when `level` < DEPTH.
  - A capture also pushes when `level`==DEPTH and a pop happens in the same cycle. In that case `level` is unchanged.
  - A capture with no room is dropped and sets `overflow`. `overflow` holds until `clr_ovf` or `rst`.
  - If a capture drops and `clr_ovf` is high in the same cycle, `overflow` stays 1 (set wins).
- **Output FSM** (states IDLE, RE, IM):
  - IDLE: when `level`>0, load head.re into `out_data`, set `out_valid`, go to RE.
  - RE: on `out_valid`&`out_ready`, load head.im into `out_data` and go to IM.
  - IM: `out_last`=1. On handshake, pop the entry. If `level` after the pop is >0, load the next head.re and go to RE (back-to-back, no bubble). Otherwise drop `out_valid` and go to IDLE.
  - `out_data`, `out_valid` and `out_last` are registered. They must not change while `out_valid`=1 and `out_ready`=0.
- The head entry is popped only on the final byte's handshake, so a record is never split by a drop.
- **Reset**: `rst`=1 at a `clk` edge gives:
  - FSM IDLE; pointers 0; `level`=0; `dcnt`=0.
  - `out_valid`=0, `out_last`=0, `out_data`=0x00, `overflow`=0.
  - A record in flight is abandoned and FIFO contents are discarded.

## Timing
- Capture on `sample_stb` at cycle N:
  - `level` increments at N+1.
  - If FSM was IDLE and the FIFO empty, `out_valid`=1 with the re byte at N+2.
- Held `out_ready`=1: one byte per cycle, 2 bytes per record (3 with timestamps), continuous across records.
- Pop effect: `level` decrements the cycle after the last-byte handshake.
- `sample_stb` period is at least 4 `clk`. Behaviour with closer pulses is still defined by the rules above.

## Configuration
- `QOSC_READER_TIMESTAMP_EN` **defined**:
  - An 8-bit step counter increments on every `sample_stb`, including decimated and dropped steps. It wraps 0xFF→0x00 and is reset to 0.
  - Entries become 24 bits {re, im, ts}.
  - FSM adds state TS after IM. `out_last` moves to the ts byte, and the pop happens on the ts handshake.
- **Undefined**: 2-byte records as described above, with no counter logic.

## Test plan
- Reset, `arm`=1, `decim`=0, one `sample_stb` with re=0x40 im=0xC0, `out_ready`=1 → at stb+2: 0x40 (`out_last`=0), then 0xC0 (`out_last`=1); `level` returns to 0 and `out_valid` drops.
- `decim`=2, 9 strobes, re=step index 0..8 → records with re=0,3,6 only, in order.
- `out_ready`=0, DEPTH+2 strobes →
  - `level`=DEPTH, `overflow`=1.
  - Draining yields the first DEPTH samples, unchanged and in order.
  - `clr_ovf` pulse → `overflow`=0.
- FIFO full and `out_ready`=1: strobe coincident with the IM-byte handshake → capture accepted, `level` stays DEPTH, `overflow` stays 0.
- Mid-record `rst` (after the re byte is accepted) → next cycle `out_valid`=0, `level`=0; a following strobe with re=0x11 emits 0x11 first.
- With `QOSC_READER_TIMESTAMP_EN`: 258 strobes at `decim`=0, draining continuously → ts bytes run 0x00..0xFF then 0x00, 0x01, with `out_last` only on ts bytes.
